mod_step_counter: RTL
=====================

# mod_step_counter

Parametrised synchronous counter that replaces the fixed-width free-running counter in the lab designs. It adds a configurable modulus, a per-cycle step, four count modes (wrap/saturate, up/down), enable, synchronous clear and parallel load. A registered wrap pulse and a saturation flag let downstream blocks build timers and prescalers.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32.
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- clear  input  1  synchronous clear of the count to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- step  input  WIDTH  increment/decrement amount per enabled cycle.
- mode  input  2  00 = wrap-up, 01 = wrap-down, 10 = saturate-up, 11 = saturate-down.
- out  output  WIDTH  current count, registered.
- wrap  output  1  registered pulse: the last update wrapped around the modulus.
- sat  output  1  registered: the last enabled step was clamped at a bound.

## Operation
- Priority per cycle: rst > clear > load > en > hold.
- rst: out = 0, wrap = 0, sat = 0.
- clear: out = 0, wrap = 0, sat = 0.
- load: out = load_val if load_val < MODULUS, else out = MODULUS-1. wrap = 0, sat = 0.
- Hold (en = 0, no clear/load): out unchanged, wrap = 0, sat = 0.
- Effective step s:
  - s = step if step < MODULUS, else s = MODULUS-1.
  - s = 0 is legal: out is unchanged and both flags are 0, except saturate modes already at the bound (see below).
- Enabled step, by mode:
  - wrap-up: if out + s >= MODULUS, out = out + s - MODULUS and wrap = 1; else out = out + s, wrap = 0. sat = 0.
  - wrap-down: if out < s, out = out + MODULUS - s and wrap = 1; else out = out - s, wrap = 0. sat = 0.
  - saturate-up: if out + s >= MODULUS-1 and s > 0, out = MODULUS-1 and sat = 1. If out == MODULUS-1 (any s), sat = 1. Otherwise out = out + s, sat = 0. wrap = 0.
  - saturate-down: if out <= s and s > 0, out = 0 and sat = 1. If out == 0 (any s), sat = 1. Otherwise out = out - s, sat = 0. wrap = 0.
- Arithmetic is performed at WIDTH+1 bits so that out + s never overflows before the modulus compare. Results are always in 0..MODULUS-1.
- Changing mode mid-count takes effect on the next enabled cycle; out is not modified by a mode change alone.
- If out is ever >= MODULUS (not reachable by design), the next enabled step reduces it as if out = MODULUS-1.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected on out/wrap/sat after edge N; latency is one cycle.
- wrap is high for exactly the one cycle following a wrapping update. Consecutive wrapping steps give consecutive high cycles.
- sat stays high on every cycle following an enabled step at or into the bound. It drops the cycle after en falls or after any clear/load.
- rst asserted mid-count overrides every other input on that edge. Counting resumes from 0 on the first edge after rst is deasserted where en = 1.
- Simultaneous clear and load: clear wins. Simultaneous load and en: the load value is taken and no step is applied that cycle.
- No combinational path from any input to any output.

## Test plan
- Reset/free-run (WIDTH=4, MODULUS=10, mode=00, step=1, en=1): rst high for 2 cycles, then release -> out = 0,1,…,9,0,1. wrap is high only in the cycle out = 0 after 9. sat stays 0.
- Stride wrap (MODULUS=10, step=3, mode=00, from 0) -> out = 3,6,9,2,5,8,1. wrap is high with out = 2 and with out = 1.
- Wrap-down (mode=01, step=4, load 5, then en) -> out = 5,1,7,3,9. wrap is high with 7 and with 9.
- Saturate (mode=10, step=4, from 0) -> 4,8,9,9. sat is high from the first 9 onward. Then drop en -> out holds 9, sat = 0 next cycle. Mode=11, step=4, from 9 -> 5,1,0,0 with sat high from the first 0.
- Priority/clamp: load=1 with load_val=15 and MODULUS=10 -> out = 9. Assert clear and load together -> out = 0. Assert load with en and load_val=4 -> out = 4, not 5. Assert step=12 -> treated as 9.
- Reset mid-operation: during a saturate-up run at out = 9 with sat = 1, pulse rst for one cycle -> out = 0, wrap = 0, sat = 0. The next en edge gives out = s.

Source files
------------

// File: rtl/mod_step_counter.sv
// Modulo counter with programmable step, wrap/saturate up/down modes,
// synchronous clear and parallel load; out, wrap and sat are all registered.
module mod_step_counter #(
    parameter int                WIDTH   = 8,
    parameter longint unsigned   MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             sat
);

    localparam logic [1:0] MODE_WRAP_UP   = 2'b00;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'b01;
    localparam logic [1:0] MODE_SAT_UP    = 2'b10;
    localparam logic [1:0] MODE_SAT_DOWN  = 2'b11;

    // Working width is one bit wider so out + step never overflows before the modulus compare.
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0]   ZERO_W = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_N = {WIDTH{1'b0}};

    logic [WIDTH-1:0] out_r;
    logic             wrap_r;
    logic             sat_r;

    logic [WIDTH:0]   cur_s;
    logic [WIDTH:0]   stp_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] nxt_s;
    logic             wrap_nxt_s;
    logic             sat_nxt_s;

    // Values at or above the modulus are pinned to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
        if ({1'b0, v} > MAX_W) begin
            return MAX_N;
        end else begin
            return v;
        end
    endfunction

    // Next count and flags for an enabled step in the current mode.
    always_comb begin
        cur_s      = {1'b0, clamp_to_max(out_r)};
        stp_s      = {1'b0, clamp_to_max(step)};
        sum_s      = cur_s + stp_s;
        nxt_s      = cur_s[WIDTH-1:0];
        wrap_nxt_s = 1'b0;
        sat_nxt_s  = 1'b0;
        case (mode)
            MODE_WRAP_UP: begin
                if (sum_s >= MOD_W) begin
                    nxt_s      = WIDTH'(sum_s - MOD_W);
                    wrap_nxt_s = 1'b1;
                end else begin
                    nxt_s      = WIDTH'(sum_s);
                end
            end
            MODE_WRAP_DOWN: begin
                if (cur_s < stp_s) begin
                    nxt_s      = WIDTH'(cur_s + (MOD_W - stp_s));
                    wrap_nxt_s = 1'b1;
                end else begin
                    nxt_s      = WIDTH'(cur_s - stp_s);
                end
            end
            MODE_SAT_UP: begin
                // Sitting on the bound keeps sat asserted even with a zero step.
                if (cur_s == MAX_W) begin
                    nxt_s     = MAX_N;
                    sat_nxt_s = 1'b1;
                end else if ((stp_s != ZERO_W) && (sum_s >= MAX_W)) begin
                    nxt_s     = MAX_N;
                    sat_nxt_s = 1'b1;
                end else begin
                    nxt_s     = WIDTH'(sum_s);
                end
            end
            MODE_SAT_DOWN: begin
                if (cur_s == ZERO_W) begin
                    nxt_s     = ZERO_N;
                    sat_nxt_s = 1'b1;
                end else if ((stp_s != ZERO_W) && (cur_s <= stp_s)) begin
                    nxt_s     = ZERO_N;
                    sat_nxt_s = 1'b1;
                end else begin
                    nxt_s     = WIDTH'(cur_s - stp_s);
                end
            end
            default: begin
                nxt_s = cur_s[WIDTH-1:0];
            end
        endcase
    end

    // State register with priority rst > clear > load > en > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= ZERO_N;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else if (clear) begin
            out_r  <= ZERO_N;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else if (load) begin
            out_r  <= clamp_to_max(load_val);
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else if (en) begin
            out_r  <= nxt_s;
            wrap_r <= wrap_nxt_s;
            sat_r  <= sat_nxt_s;
        end else begin
            out_r  <= out_r;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end
    end

    assign out  = out_r;
    assign wrap = wrap_r;
    assign sat  = sat_r;

endmodule
